operand_buffer: RTL and testbench
=================================

OPERAND_BUFFER -- requirements
Module: operand_buffer

Interface
REQ-001 Parameter DATA_W, default 8: operand element width in bits, DATA_W >= 1.
REQ-002 Parameter DIM, default 2: matrix dimension; each matrix is DIM x DIM, DIM >= 1.
REQ-003 Derived constants: ELEMS = DIM*DIM; DEPTH = 2*ELEMS (weights then inputs); CW = $clog2(DEPTH+1).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous clear of buffer state, active-high.
REQ-007 load_valid  in  1  producer presents load_data.
REQ-008 load_data  in  DATA_W  operand element to store.
REQ-009 load_ready  out  1  buffer accepts an element this cycle.
REQ-010 load_done  out  1  one-cycle pulse: shadow bank completely loaded.
REQ-011 act_valid  out  1  active bank holds a complete operand set.
REQ-012 act_release  in  1  consumer finished with the active set.
REQ-013 weights_flat  out  ELEMS*DATA_W  active weights; element k at bits [k*DATA_W +: DATA_W], row-major.
REQ-014 inputs_flat  out  ELEMS*DATA_W  active inputs; same packing.
REQ-015 fill_cnt  out  CW  elements held in shadow bank (0..DEPTH).
REQ-016 bank_sel  out  1  index of the active (read) bank.

Function
REQ-017 Storage: two banks of DEPTH elements each; per bank a full flag; rd_bank register; shadow bank = ~rd_bank.
REQ-018 Bank address map: 0..ELEMS-1 weights, ELEMS..DEPTH-1 inputs.
REQ-019 load_ready = !full[shadow] && !flush (combinational).
REQ-020 Accept = load_valid && load_ready; element written to shadow[wr_ptr], wr_ptr increments.
REQ-021 On accept with wr_ptr == DEPTH-1: wr_ptr wraps to 0, full[shadow] set, load_done high for exactly the next cycle.
REQ-022 load_valid while load_ready = 0 is ignored; no write, no pointer change.
REQ-023 act_valid = full[rd_bank]; act_release while act_valid = 0 is ignored.
REQ-024 act_release while act_valid = 1 clears full[rd_bank] at that edge.
REQ-025 Swap: at an edge where the active bank is empty or being released and full[shadow] = 1, rd_bank toggles in that same edge.
REQ-026 Shadow becoming full while active already empty: swap occurs on the following edge (1-cycle latency from final accept to act_valid).
REQ-027 Release of active with shadow not full: no swap; act_valid low until shadow fills; loading continues uninterrupted.
REQ-028 weights_flat/inputs_flat: combinational read of rd_bank storage, forced to all-zero while act_valid = 0.
REQ-029 fill_cnt = DEPTH when full[shadow], else wr_ptr.
REQ-030 flush (priority over load and release): clears both full flags, wr_ptr, rd_bank, load_done; storage contents retained but unobservable.
REQ-031 Final accept coincident with release of the active set: both take effect; swap per REQ-025 on the following edge.

Reset
REQ-032 rst_n low asynchronously clears storage to 0, full flags, wr_ptr, rd_bank and load_done to 0.
REQ-033 Output values while in reset: load_ready 1, load_done 0, act_valid 0, flat buses 0, fill_cnt 0, bank_sel 0.
REQ-034 Reset asserted mid-load or mid-compute discards all partial and complete sets; first accept after release writes weights element 0.

Verification (DATA_W=8, DIM=2)
REQ-035 Reset, stream 0x01..0x08 with load_valid held -> load_ready 1 throughout; load_done pulse cycle after 8th accept; act_valid next cycle; weights_flat 0x04030201, inputs_flat 0x08070605, bank_sel 1.
REQ-036 With set 1 active, stream 0x11..0x18 plus a 9th 0x99 -> 8 accepted, load_ready 0, fill_cnt 8; pulse act_release -> bank_sel 0, weights_flat 0x14131211, load_ready 1, 0x99 accepted next cycle, fill_cnt 1.
REQ-037 Active set held, 3 elements loaded, act_release -> act_valid 0, flat buses 0, fill_cnt 3; 5 more elements -> act_valid after 1-cycle latency.
REQ-038 flush after 5 accepts -> load_ready 0 in flush cycle, fill_cnt 0, act_valid 0, bank_sel 0; reload 0x21..0x28 -> weights_flat 0x24232221.
REQ-039 rst_n pulsed low between clock edges mid-stream -> outputs 0 immediately per REQ-033 without a clock edge; reload behaves as REQ-035.
REQ-040 act_release with act_valid 0 and load_valid 0 for 10 cycles -> no state change, fill_cnt and bank_sel constant.

Source files
------------

// File: rtl/operand_buffer.sv
// Double-buffered operand store: a producer fills the shadow bank (weights, then inputs)
// while a consumer reads the active bank. The banks swap as soon as the active set is free.
module operand_buffer #(
  parameter int DATA_W = 8,
  parameter int DIM = 2,
  localparam int ELEMS = DIM * DIM,
  localparam int DEPTH = 2 * ELEMS,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    load_valid,
  input  logic [DATA_W-1:0]       load_data,
  output logic                    load_ready,
  output logic                    load_done,
  output logic                    act_valid,
  input  logic                    act_release,
  output logic [ELEMS*DATA_W-1:0] weights_flat,
  output logic [ELEMS*DATA_W-1:0] inputs_flat,
  output logic [CW-1:0]           fill_cnt,
  output logic                    bank_sel
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [DATA_W-1:0] mem_d [2][DEPTH];
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              load_done_q, load_done_d;

  logic shadow;
  logic accept;
  logic last;
  logic release_act;
  logic swap;

  // Handshake: an element transfers on a rising edge where load_valid && load_ready;
  // load_valid without load_ready is simply held off, nothing is written.
  assign shadow      = ~rd_bank_q;
  assign load_ready  = !full_q[shadow] && !flush;
  assign accept      = load_valid && load_ready;
  assign last        = (wr_ptr_q == AW'(DEPTH - 1));
  assign release_act = act_release && full_q[rd_bank_q];
  // A full shadow can take over only once the active bank is empty or being let go.
  assign swap        = full_q[shadow] && (!full_q[rd_bank_q] || release_act);

  always_comb begin
    mem_d       = mem_q;
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    wr_ptr_d    = wr_ptr_q;
    load_done_d = 1'b0;
    if (flush) begin
      full_d    = '0;
      wr_ptr_d  = '0;
      rd_bank_d = 1'b0;
    end else begin
      if (release_act) full_d[rd_bank_q] = 1'b0;
      if (swap)        rd_bank_d = ~rd_bank_q;
      if (accept) begin
        mem_d[shadow][wr_ptr_q] = load_data;
        if (last) begin
          wr_ptr_d       = '0;
          full_d[shadow] = 1'b1;
          load_done_d    = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      full_q      <= '0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      load_done_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      load_done_q <= load_done_d;
    end
  end

  assign load_done = load_done_q;
  assign act_valid = full_q[rd_bank_q];
  assign bank_sel  = rd_bank_q;
  assign fill_cnt  = full_q[shadow] ? CW'(DEPTH) : CW'(wr_ptr_q);

  // Weights occupy the low half of a bank, inputs the high half; hidden while no set is active.
  for (genvar k = 0; k < ELEMS; k++) begin : g_flat
    assign weights_flat[k*DATA_W +: DATA_W] = act_valid ? mem_q[rd_bank_q][k]         : '0;
    assign inputs_flat[k*DATA_W +: DATA_W]  = act_valid ? mem_q[rd_bank_q][k + ELEMS] : '0;
  end

endmodule

// File: tb/tb_operand_buffer.sv
// Bench for operand_buffer: directed scenarios plus random traffic, checked against a
// set-level reference model with a queue of expected operand sets.
module tb_operand_buffer;

  localparam int DATA_W = 8;
  localparam int DIM    = 2;
  localparam int ELEMS  = DIM * DIM;
  localparam int DEPTH  = 2 * ELEMS;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int SW     = DEPTH * DATA_W;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    load_valid;
  logic [DATA_W-1:0]       load_data;
  logic                    load_ready;
  logic                    load_done;
  logic                    act_valid;
  logic                    act_release;
  logic [ELEMS*DATA_W-1:0] weights_flat;
  logic [ELEMS*DATA_W-1:0] inputs_flat;
  logic [CW-1:0]           fill_cnt;
  logic                    bank_sel;

  operand_buffer #(.DATA_W(DATA_W), .DIM(DIM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .act_valid    (act_valid),
    .act_release  (act_release),
    .weights_flat (weights_flat),
    .inputs_flat  (inputs_flat),
    .fill_cnt     (fill_cnt),
    .bank_sel     (bank_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: tracks whole operand sets, not banks or pointers
  bit                m_active;
  bit                m_pend;
  bit                m_bank;
  bit                m_done;
  int                m_cnt;
  logic [DATA_W-1:0] cur_q[$];
  logic [SW-1:0]     exp_q[$];
  logic [SW-1:0]     set_w;
  bit                m_rel;
  bit                m_promote;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      m_active = 0; m_pend = 0; m_bank = 0; m_done = 0; m_cnt = 0;
      cur_q.delete();
      exp_q.delete();
    end else begin
      m_rel     = act_release && m_active;
      m_promote = m_pend && (!m_active || m_rel);
      m_done    = 0;
      if (load_valid && !m_pend) begin
        cur_q.push_back(load_data);
        m_cnt++;
        if (m_cnt == DEPTH) begin
          set_w = '0;
          for (int k = 0; k < DEPTH; k++) set_w[k*DATA_W +: DATA_W] = cur_q[k];
          exp_q.push_back(set_w);
          cur_q.delete();
          m_cnt  = 0;
          m_done = 1;
        end
      end
      if (m_rel) m_active = 0;
      if (m_promote) begin
        m_active = 1;
        m_pend   = 0;
        m_bank   = ~m_bank;
      end
      if (m_done) m_pend = 1;
    end
  end

  // monitor / scoreboard
  bit            prev_v = 0;
  bit            prev_b = 0;
  logic [SW-1:0] exp_set;

  always @(negedge clk) begin
    chk("load_ready", 64'(load_ready), 64'(!m_pend && !flush));
    chk("fill_cnt",   64'(fill_cnt),   64'(m_pend ? DEPTH : m_cnt));
    chk("act_valid",  64'(act_valid),  64'(m_active));
    chk("load_done",  64'(load_done),  64'(m_done));
    chk("bank_sel",   64'(bank_sel),   64'(m_bank));
    if (act_valid && (!prev_v || bank_sel != prev_b)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL set_pop: got a new active set, expected none queued (t=%0t)", $time);
      end else begin
        exp_set = exp_q.pop_front();
        chk("operand_set", 64'({inputs_flat, weights_flat}), 64'(exp_set));
      end
    end else if (!act_valid) begin
      chk("flat_zero", 64'({inputs_flat, weights_flat}), 64'd0);
    end
    prev_v = act_valid;
    prev_b = bank_sel;
  end

  // driver tasks: called and return at posedge+2
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bit got;
    int budget;
    got = 0;
    budget = 40;
    load_valid = 1'b1;
    load_data  = d;
    while (!got && budget > 0) begin
      @(negedge clk);
      got = load_ready;
      @(posedge clk);
      #2;
      budget--;
    end
    load_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL send_timeout: data %0h got no load_ready, required within 40 cycles", d);
    end
  endtask

  task automatic pulse_release();
    act_release = 1'b1;
    idle(1);
    act_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; load_valid = 1'b0; load_data = '0; act_release = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);

    // first set streamed back to back
    for (int i = 1; i <= 8; i++) send(DATA_W'(i));
    idle(3);
    chk("w_first", 64'(weights_flat), 64'h04030201);
    chk("i_first", 64'(inputs_flat),  64'h08070605);
    chk("bank_first", 64'(bank_sel), 64'd1);

    // second set plus an extra element that must wait for a release
    fork
      begin
        for (int i = 0; i < 8; i++) send(DATA_W'(8'h11 + i));
        send(8'h99);
      end
      begin
        idle(12);
        chk("fill_full", 64'(fill_cnt), 64'd8);
        chk("ready_full", 64'(load_ready), 64'd0);
        pulse_release();
      end
    join
    chk("fill_after_swap", 64'(fill_cnt), 64'd1);
    chk("bank_after_swap", 64'(bank_sel), 64'd0);
    chk("w_second", 64'(weights_flat), 64'h14131211);

    // release with a partially loaded shadow
    send(8'h9a);
    send(8'h9b);
    pulse_release();
    chk("valid_after_rel", 64'(act_valid), 64'd0);
    chk("fill_partial", 64'(fill_cnt), 64'd3);
    chk("w_zero", 64'(weights_flat), 64'd0);
    for (int i = 0; i < 5; i++) send(DATA_W'(8'h9c + i));
    chk("valid_latency", 64'(act_valid), 64'd0);
    idle(1);
    chk("valid_after_fill", 64'(act_valid), 64'd1);
    chk("w_third", 64'(weights_flat), 64'h9c9b9a99);

    // flush mid-load
    for (int i = 0; i < 5; i++) send(DATA_W'(8'hb0 + i));
    flush = 1'b1;
    #1;
    chk("ready_in_flush", 64'(load_ready), 64'd0);
    @(posedge clk);
    #2;
    flush = 1'b0;
    chk("fill_flush", 64'(fill_cnt), 64'd0);
    chk("valid_flush", 64'(act_valid), 64'd0);
    chk("bank_flush", 64'(bank_sel), 64'd0);
    for (int i = 0; i < 8; i++) send(DATA_W'(8'h21 + i));
    idle(2);
    chk("w_after_flush", 64'(weights_flat), 64'h24232221);

    // asynchronous reset between edges, mid-stream
    for (int i = 0; i < 3; i++) send(DATA_W'(8'h41 + i));
    load_valid = 1'b1;
    load_data  = 8'h44;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(load_ready), 64'd1);
    chk("rst_done",  64'(load_done),  64'd0);
    chk("rst_valid", 64'(act_valid),  64'd0);
    chk("rst_flat",  64'({inputs_flat, weights_flat}), 64'd0);
    chk("rst_fill",  64'(fill_cnt),   64'd0);
    chk("rst_bank",  64'(bank_sel),   64'd0);
    load_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send(DATA_W'(i));
    idle(3);
    chk("w_after_rst", 64'(weights_flat), 64'h04030201);
    chk("i_after_rst", 64'(inputs_flat),  64'h08070605);
    chk("bank_after_rst", 64'(bank_sel), 64'd1);

    // release with nothing active is ignored
    pulse_release();
    act_release = 1'b1;
    idle(10);
    act_release = 1'b0;
    chk("idle_fill", 64'(fill_cnt), 64'd0);
    chk("idle_bank", 64'(bank_sel), 64'd1);
    chk("idle_valid", 64'(act_valid), 64'd0);

    // random traffic
    repeat (600) begin
      load_valid  = ($urandom_range(0, 99) < 70);
      load_data   = DATA_W'($urandom);
      act_release = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 199) == 0);
      idle(1);
    end
    load_valid = 1'b0; flush = 1'b0;
    act_release = 1'b1;
    idle(4);
    act_release = 1'b0;
    idle(1);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
